thor2025_regfile_lvt: RTL

THOR2025_REGFILE_LVT -- requirements
Module: thor2025_regfile_lvt

---
 rtl/thor2025_pkg.sv | 19 +
 rtl/thor2025_regfile_bank.sv | 42 ++++
 rtl/thor2025_regfile_lvt.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/thor2025_pkg.sv
// Shared definitions for the thor2025 register-file slice.
//   - default data width and the byte-lane width/count derived from it
//   - LVT entry type (wide enough to name any of up to 4 write ports)
//   - two-state controller encoding (CLEAR sweep / READY)
package thor2025_pkg;

  localparam int unsigned WID_DEF = 64;
  localparam int unsigned LANE_W  = 8;
  localparam int unsigned NL_DEF  = WID_DEF / LANE_W;
  localparam int unsigned LVT_W   = 2;

  typedef logic [LVT_W-1:0] lvt_t;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

endpackage

// File: rtl/thor2025_regfile_bank.sv
// One 1-write/1-read bank of the LVT register file.
//   clk : clock
//   we  : byte-lane write enables
//   wa  : write address
//   wd  : write data
//   ra  : read address, sampled on the rising edge
//   rd  : registered read data (old contents on a same-edge write)
module thor2025_regfile_bank
  import thor2025_pkg::*;
#(
  parameter int unsigned WID   = WID_DEF,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned NL    = WID / LANE_W,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic [NL-1:0]  we,
  input  logic [AW-1:0]  wa,
  input  logic [WID-1:0] wd,
  input  logic [AW-1:0]  ra,
  output logic [WID-1:0] rd
);

  logic [WID-1:0] mem [DEPTH];
  logic [WID-1:0] rd_d;
  logic [WID-1:0] rd_q;

  always_comb begin
    rd_d = '0;
    if (32'(ra) < DEPTH) rd_d = mem[ra];
  end

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NL; b++) begin
      if (we[b]) mem[wa][b*LANE_W +: LANE_W] <= wd[b*LANE_W +: LANE_W];
    end
    rd_q <= rd_d;
  end

  assign rd = rd_q;

endmodule

// File: rtl/thor2025_regfile_lvt.sv
// Multi-ported register file built from NWR x NRD 1W1R banks plus a
// flop-based live value table recording, per register and byte lane, which
// write port wrote last.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous request to zero the whole file
//   rdy      : file is out of its clear sweep and usable
//   wr/we/wa/wd : per write port enable, byte-lane enables, address, data
//   ra/o     : per read port address (sampled) and data (valid after edge)
module thor2025_regfile_lvt
  import thor2025_pkg::*;
#(
  parameter int unsigned WID     = WID_DEF,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned NWR     = 3,
  parameter int unsigned NRD     = 8,
  parameter bit          ZERO_R0 = 1'b1,
  parameter int unsigned NL      = WID / LANE_W,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  output logic                    rdy,
  input  logic [NWR-1:0]          wr,
  input  logic [NWR-1:0][NL-1:0]  we,
  input  logic [NWR-1:0][AW-1:0]  wa,
  input  logic [NWR-1:0][WID-1:0] wd,
  input  logic [NRD-1:0][AW-1:0]  ra,
  output logic [NRD-1:0][WID-1:0] o
);

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  state_e         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic           rdy_q, rdy_d;

  lvt_t           lvt_q [DEPTH][NL];
  lvt_t           lvt_d [DEPTH][NL];

  // Sampled-read state: address validity, LVT selection, bypass lanes.
  logic [NRD-1:0]          val_q, val_d;
  lvt_t                    sel_q [NRD][NL];
  lvt_t                    sel_d [NRD][NL];
  logic [NRD-1:0][NL-1:0]  byp_v_q, byp_v_d;
  logic [NRD-1:0][WID-1:0] byp_d_q, byp_d_d;

  logic [NWR-1:0][NL-1:0]  eff_we;
  logic [NWR-1:0][NL-1:0]  bk_we;
  logic [NWR-1:0][AW-1:0]  bk_wa;
  logic [NWR-1:0][WID-1:0] bk_wd;
  logic [WID-1:0]          bank_rd [NWR][NRD];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    case (state_q)
      CLEAR: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = READY;
          rdy_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          rdy_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // User writes are dropped on the edge that accepts clr; during the sweep
  // every bank is driven by the sweep counter instead.
  always_comb begin
    eff_we = '0;
    bk_we  = '0;
    bk_wa  = '0;
    bk_wd  = '0;
    for (int unsigned p = 0; p < NWR; p++) begin
      for (int unsigned b = 0; b < NL; b++) begin
        eff_we[p][b] = rdy_q && !clr && wr[p] && we[p][b] && in_range(wa[p]);
      end
      if (state_q == CLEAR) begin
        bk_we[p] = '1;
        bk_wa[p] = cnt_q;
        bk_wd[p] = '0;
      end else begin
        bk_we[p] = eff_we[p];
        bk_wa[p] = wa[p];
        bk_wd[p] = wd[p];
      end
    end
  end

  // Ascending port order lets the highest port win a same-edge collision.
  always_comb begin
    lvt_d = lvt_q;
    for (int unsigned p = 0; p < NWR; p++) begin
      for (int unsigned b = 0; b < NL; b++) begin
        if (eff_we[p][b]) lvt_d[wa[p]][b] = lvt_t'(p);
      end
    end
    if (state_q == CLEAR) begin
      for (int unsigned b = 0; b < NL; b++) lvt_d[cnt_q][b] = '0;
    end
  end

  // The banks return pre-write contents, so a same-edge write to the sampled
  // address is captured here and overrides the bank data lane by lane.
  always_comb begin
    val_d   = '0;
    byp_v_d = '0;
    byp_d_d = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      val_d[k] = in_range(ra[k])
               && !(ZERO_R0 && ra[k] == '0)
               && !(state_q == CLEAR && ra[k] == cnt_q);
      for (int unsigned b = 0; b < NL; b++) begin
        sel_d[k][b] = in_range(ra[k]) ? lvt_q[ra[k]][b] : '0;
        for (int unsigned p = 0; p < NWR; p++) begin
          if (eff_we[p][b] && wa[p] == ra[k]) begin
            byp_v_d[k][b]                  = 1'b1;
            byp_d_d[k][b*LANE_W +: LANE_W] = wd[p][b*LANE_W +: LANE_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      val_q   <= '0;
      byp_v_q <= '0;
      byp_d_q <= '0;
      for (int unsigned a = 0; a < DEPTH; a++) begin
        for (int unsigned b = 0; b < NL; b++) lvt_q[a][b] <= '0;
      end
      for (int unsigned k = 0; k < NRD; k++) begin
        for (int unsigned b = 0; b < NL; b++) sel_q[k][b] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      val_q   <= val_d;
      byp_v_q <= byp_v_d;
      byp_d_q <= byp_d_d;
      lvt_q   <= lvt_d;
      sel_q   <= sel_d;
    end
  end

  for (genvar p = 0; p < NWR; p++) begin : g_wr
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      thor2025_regfile_bank #(
        .WID   (WID),
        .DEPTH (DEPTH),
        .NL    (NL),
        .AW    (AW)
      ) u_bank (
        .clk (clk),
        .we  (bk_we[p]),
        .wa  (bk_wa[p]),
        .wd  (bk_wd[p]),
        .ra  (ra[k]),
        .rd  (bank_rd[p][k])
      );
    end
  end

  always_comb begin
    o = '0;
    if (rdy_q) begin
      for (int unsigned k = 0; k < NRD; k++) begin
        if (val_q[k]) begin
          for (int unsigned b = 0; b < NL; b++) begin
            if (byp_v_q[k][b]) begin
              o[k][b*LANE_W +: LANE_W] = byp_d_q[k][b*LANE_W +: LANE_W];
            end else begin
              for (int unsigned p = 0; p < NWR; p++) begin
                if (sel_q[k][b] == lvt_t'(p)) o[k][b*LANE_W +: LANE_W] = bank_rd[p][k][b*LANE_W +: LANE_W];
              end
            end
          end
        end
      end
    end
  end

  assign rdy = rdy_q;

endmodule
